// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: requester, result and status bundle for mult_arbiter (i_lock only with MULT_ARB_LOCK_EN)
interface mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
);
  logic [NUM_REQ-1:0] i_req_valid;
  logic [NUM_REQ-1:0] o_req_ready;
  logic [4*NUM_REQ-1:0] i_req_a;
  logic [4*NUM_REQ-1:0] i_req_b;
`ifdef MULT_ARB_LOCK_EN
  logic [NUM_REQ-1:0] i_lock;
`endif
  logic o_res_valid;
  logic i_res_ready;
  logic [ID_W-1:0] o_res_id;
  logic [7:0] o_result;
  logic o_busy;
  modport slave (
    input i_req_valid, i_req_a, i_req_b, i_res_ready,
`ifdef MULT_ARB_LOCK_EN
    input i_lock,
`endif
    output o_req_ready, o_res_valid, o_res_id, o_result, o_busy
  );
  modport master (
    output i_req_valid, i_req_a, i_req_b, i_res_ready,
`ifdef MULT_ARB_LOCK_EN
    output i_lock,
`endif
    input o_req_ready, o_res_valid, o_res_id, o_result, o_busy
  );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin share of a 2-stage 4x4 multiplier (clk, reset, bus slave), burst lock with MULT_ARB_LOCK_EN
module mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int LOCK_MAX = 8
) (
  input logic clk,
  input logic reset,
  mult_arbiter_if.slave bus
);
  if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 || LOCK_MAX < 1 || LOCK_MAX > 255) begin : g_bad_param
    $error("mult_arbiter: illegal parameters");
  end
  logic en, acc, s1_v, s2_v;
  logic [ID_W-1:0] ptr, gid, nxt, s1_id, s2_id;
  logic [3:0] a_sel, b_sel, s1_a, s1_b;
  logic [7:0] s2_p;
  assign en = (!s2_v || bus.i_res_ready) && !reset;
  always_comb begin
    acc = 1'b0;
    gid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (en && !acc && bus.i_req_valid[(int'(ptr) + i) % NUM_REQ]) begin
        acc = 1'b1;
        gid = ID_W'((int'(ptr) + i) % NUM_REQ);
      end
  end
  assign bus.o_req_ready = acc ? NUM_REQ'(1) << gid : '0;
  assign a_sel = bus.i_req_a[{gid, 2'b00} +: 4];
  assign b_sel = bus.i_req_b[{gid, 2'b00} +: 4];
  assign nxt = (gid == ID_W'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
`ifdef MULT_ARB_LOCK_EN
  logic [7:0] cnt, cnt_n;
  assign cnt_n = ((gid == ptr) ? cnt : 8'd0) + 8'd1;
  always_ff @(posedge clk)
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (acc) begin
      ptr <= (bus.i_lock[gid] && cnt_n < 8'(LOCK_MAX)) ? gid : nxt;
      cnt <= (bus.i_lock[gid] && cnt_n < 8'(LOCK_MAX)) ? cnt_n : 8'd0;
    end
`else
  always_ff @(posedge clk)
    if (reset) ptr <= '0;
    else if (acc) ptr <= nxt;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_id <= '0;
      s2_v <= 1'b0;
      s2_p <= '0;
      s2_id <= '0;
    end else if (en) begin
      s1_v <= acc;
      s1_a <= a_sel;
      s1_b <= b_sel;
      s1_id <= gid;
      s2_v <= s1_v;
      s2_p <= {4'b0, s1_a} * {4'b0, s1_b};
      s2_id <= s1_id;
    end
  assign bus.o_res_valid = s2_v;
  assign bus.o_result = s2_p;
  assign bus.o_res_id = s2_id;
  assign bus.o_busy = s1_v || s2_v;
endmodule
